regfile_bypass: RTL and testbench

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_bypass_pkg.sv | 27 ++
 rtl/regfile_bypass_fwd_mux.sv | 66 ++++++
 rtl/regfile_bypass.sv | 92 +++++++++
 tb/tb_regfile_bypass.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_bypass_pkg.sv
// Shared defines for the forwarding register file: default widths, zero-register index, enables.
// Compile-time constants and types only.
package regfile_bypass_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_CNT_W  = 16;
    localparam int ZERO_REG   = 0;

    // Where a read port takes its value from, lowest to highest priority.
    typedef enum logic [1:0] {
        SRC_ARR = 2'd0,
        SRC_WB  = 2'd1,
        SRC_MEM = 2'd2,
        SRC_EX  = 2'd3
    } fwd_src_e;

    function automatic int reg_num(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/regfile_bypass_fwd_mux.sv
// One read port's forwarding mux: EX > MEM > WB > array; r0, disabled port and reset read 0.
// Latency: combinational. Backpressure: none; reports an EX hit so the top can raise a load-use stall.
module fwd_mux
    import regfile_bypass_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_rst,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_ex_we,
    input  logic [ADDR_W-1:0] i_ex_waddr,
    input  logic [DATA_W-1:0] i_ex_wdata,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_waddr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_waddr,
    input  logic [DATA_W-1:0] i_wb_wdata,
    input  logic [DATA_W-1:0] i_arr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_ex_hit
);

    localparam logic [ADDR_W-1:0] W_ZERO = ADDR_W'(ZERO_REG);

    logic     w_active;
    logic     w_ex_hit;
    logic     w_mem_hit;
    logic     w_wb_hit;
    fwd_src_e w_src;

    assign w_active  = (i_rst != RstEnable) && (i_rd_en == ReadEnable) && (i_rd_addr != W_ZERO);

    // Writes aimed at r0 never match, so nothing can forward into the zero register.
    assign w_ex_hit  = (i_ex_we  == WriteEnable) && (i_ex_waddr  == i_rd_addr) && (i_ex_waddr  != W_ZERO);
    assign w_mem_hit = (i_mem_we == WriteEnable) && (i_mem_waddr == i_rd_addr) && (i_mem_waddr != W_ZERO);
    assign w_wb_hit  = (i_wb_we  == WriteEnable) && (i_wb_waddr  == i_rd_addr) && (i_wb_waddr  != W_ZERO);

    always_comb begin
        w_src = SRC_ARR;
        if (w_ex_hit) begin
            w_src = SRC_EX;
        end else if (w_mem_hit) begin
            w_src = SRC_MEM;
        end else if (w_wb_hit) begin
            w_src = SRC_WB;
        end
    end

    always_comb begin
        o_rd_data = '0;
        if (w_active) begin
            case (w_src)
                SRC_EX:  o_rd_data = i_ex_wdata;
                SRC_MEM: o_rd_data = i_mem_wdata;
                SRC_WB:  o_rd_data = i_wb_wdata;
                default: o_rd_data = i_arr_data;
            endcase
        end
    end

    assign o_ex_hit = w_active && w_ex_hit;

endmodule

// File: rtl/regfile_bypass.sv
// Register file with EX/MEM/WB forwarding, load-use stall detection and a saturating stall counter.
// Latency: reads combinational, writes one cycle. Backpressure: stall_req asks the pipeline to hold ID.
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     ex_we,
    input  logic [ADDR_W-1:0]        ex_waddr,
    input  logic [DATA_W-1:0]        ex_wdata,
    input  logic                     ex_is_load,
    input  logic                     mem_we,
    input  logic [ADDR_W-1:0]        mem_waddr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_waddr,
    input  logic [DATA_W-1:0]        wb_wdata,
    output logic                     stall_req,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int                REG_NUM = reg_num(ADDR_W);
    localparam logic [ADDR_W-1:0] W_ZERO  = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_regs [REG_NUM];
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [NUM_RD-1:0] w_ex_hit;
    logic              w_stall;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((wb_we == WriteEnable) && (wb_waddr != W_ZERO)) begin
            r_regs[wb_waddr] <= wb_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_arr_data;

        assign w_addr     = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_arr_data = r_regs[w_addr];

        fwd_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_fwd_mux (
            .i_rst       (rst),
            .i_rd_en     (rd_en[k]),
            .i_rd_addr   (w_addr),
            .i_ex_we     (ex_we),
            .i_ex_waddr  (ex_waddr),
            .i_ex_wdata  (ex_wdata),
            .i_mem_we    (mem_we),
            .i_mem_waddr (mem_waddr),
            .i_mem_wdata (mem_wdata),
            .i_wb_we     (wb_we),
            .i_wb_waddr  (wb_waddr),
            .i_wb_wdata  (wb_wdata),
            .i_arr_data  (w_arr_data),
            .o_rd_data   (rd_data[k*DATA_W +: DATA_W]),
            .o_ex_hit    (w_ex_hit[k])
        );
    end

    // An EX hit already implies reset low, port enabled and a nonzero address.
    assign w_stall   = (ex_is_load == 1'b1) && (|w_ex_hit);
    assign stall_req = w_stall;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: a reference model checked every cycle plus literal spot checks.
module tb_regfile_bypass;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] rd_en;
    logic [AW-1:0] ra [NR];
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data, rd_data_s;
    logic          ex_we, ex_is_load, mem_we, wb_we;
    logic [AW-1:0] ex_waddr, mem_waddr, wb_waddr;
    logic [DW-1:0] ex_wdata, mem_wdata, wb_wdata;
    logic          stall_req, stall_req_s;
    logic [15:0]   stall_cnt;
    logic [1:0]    stall_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_regs [32];
    int            m_cnt   = 0;
    int            m_cnt_s = 0;

    assign rd_addr = {ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .stall_req(stall_req), .stall_cnt(stall_cnt)
    );

    regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .stall_req(stall_req_s), .stall_cnt(stall_cnt_s)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference read: the value a port must see under the source-priority rules.
    function automatic logic [DW-1:0] m_read(input logic en, input logic [AW-1:0] a);
        if (rst || !en || a == 0) return '0;
        if (ex_we  && ex_waddr  == a) return ex_wdata;
        if (mem_we && mem_waddr == a) return mem_wdata;
        if (wb_we  && wb_waddr  == a) return wb_wdata;
        return m_regs[a];
    endfunction

    function automatic logic m_stall();
        logic s = 1'b0;
        for (int k = 0; k < NR; k++)
            if (rd_en[k] && ra[k] == ex_waddr) s = 1'b1;
        return !rst && ex_we && ex_is_load && (ex_waddr != 0) && s;
    endfunction

    initial for (int i = 0; i < 32; i++) m_regs[i] = '0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt   = 0;
            m_cnt_s = 0;
        end else begin
            if (m_stall()) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
            if (wb_we && wb_waddr != 0) m_regs[wb_waddr] = wb_wdata;
        end
    end

    always @(negedge clk) begin
        logic st;
        st = m_stall();
        chk("cyc_stall_req", {63'd0, stall_req}, {63'd0, st});
        chk("cyc_stall_req_s", {63'd0, stall_req_s}, {63'd0, st});
        chk("cyc_stall_cnt", {48'd0, stall_cnt}, 64'(m_cnt));
        chk("cyc_stall_cnt_s", {62'd0, stall_cnt_s}, 64'(m_cnt_s));
        for (int k = 0; k < NR; k++) begin
            if (!(st && rd_en[k] && ra[k] == ex_waddr)) begin
                chk("cyc_rd", {32'd0, rd_data[k*DW +: DW]}, {32'd0, m_read(rd_en[k], ra[k])});
                chk("cyc_rd_s", {32'd0, rd_data_s[k*DW +: DW]}, {32'd0, m_read(rd_en[k], ra[k])});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_src();
        ex_we = 0; ex_is_load = 0; mem_we = 0; wb_we = 0;
        ex_waddr = 0; mem_waddr = 0; wb_waddr = 0;
        ex_wdata = 0; mem_wdata = 0; wb_wdata = 0;
    endtask

    task automatic lit_rd(input string nm, input int port, input logic [DW-1:0] exp);
        #2;
        chk(nm, {32'd0, rd_data[port*DW +: DW]}, {32'd0, exp});
    endtask

    initial begin
        rst = 1; rd_en = '0; ra[0] = 0; ra[1] = 0;
        clr_src();
        repeat (10) tick();
        rst = 0; rd_en = 2'b11;

        for (int r = 1; r < 32; r++) begin
            ra[0] = AW'(r); ra[1] = AW'(32 - r);
            #2;
            chk("reset_rd0", {32'd0, rd_data[0 +: DW]}, 64'd0);
            chk("reset_rd1", {32'd0, rd_data[DW +: DW]}, 64'd0);
            tick();
        end
        chk("reset_cnt", {48'd0, stall_cnt}, 64'd0);

        // ori chain on r1, values moving EX -> MEM -> WB
        ra[0] = 1; ra[1] = 2;
        ex_we = 1; ex_waddr = 1; ex_wdata = 32'h1100;
        lit_rd("ori_1100", 0, 32'h0000_1100); tick();
        mem_we = 1; mem_waddr = 1; mem_wdata = 32'h1100; ex_wdata = 32'h1120;
        lit_rd("ori_1120", 0, 32'h0000_1120); tick();
        wb_we = 1; wb_waddr = 1; wb_wdata = 32'h1100; mem_wdata = 32'h1120; ex_wdata = 32'h5520;
        lit_rd("ori_5520", 0, 32'h0000_5520); tick();
        wb_wdata = 32'h1120; mem_wdata = 32'h5520; ex_wdata = 32'h5564;
        lit_rd("ori_5564", 0, 32'h0000_5564); tick();
        ex_we = 0; wb_wdata = 32'h5520; mem_wdata = 32'h5564;
        lit_rd("ori_mem", 0, 32'h0000_5564); tick();
        clr_src(); wb_we = 1; wb_waddr = 1; wb_wdata = 32'h5564; tick();
        clr_src();
        lit_rd("ori_arr", 0, 32'h0000_5564); tick();

        // same-cycle WB bypass, then array
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEAD_BEEF; ra[0] = 5; ra[1] = 5;
        lit_rd("wb_byp", 0, 32'hDEAD_BEEF);
        chk("wb_byp_p1", {32'd0, rd_data[DW +: DW]}, 64'hDEAD_BEEF);
        tick();
        clr_src();
        lit_rd("wb_arr", 1, 32'hDEAD_BEEF); tick();

        // priority with all three sources on r6, and a disabled port
        ra[0] = 6; ra[1] = 6;
        ex_we = 1; ex_waddr = 6; ex_wdata = 32'hE;
        mem_we = 1; mem_waddr = 6; mem_wdata = 32'hA;
        wb_we = 1; wb_waddr = 6; wb_wdata = 32'hB;
        lit_rd("prio_ex", 1, 32'hE); tick();
        ex_we = 0;
        lit_rd("prio_mem", 0, 32'hA); tick();
        mem_we = 0;
        lit_rd("prio_wb", 1, 32'hB); tick();
        rd_en = 2'b01;
        lit_rd("rd_en_low", 1, 32'h0); tick();
        clr_src(); rd_en = 2'b11;
        wb_we = 1; wb_waddr = 7; wb_wdata = 32'hAA; tick();
        clr_src();

        // load-use stall
        ex_we = 1; ex_is_load = 1; ex_waddr = 3; ex_wdata = 32'h77; ra[0] = 9; ra[1] = 3;
        #2; chk("stall_hit", {63'd0, stall_req}, 64'd1);
        tick();
        ra[1] = 4;
        #2; chk("stall_miss", {63'd0, stall_req}, 64'd0);
        chk("stall_cnt1", {48'd0, stall_cnt}, 64'd1);
        tick();

        // writes to r0 from every stage
        ex_waddr = 0; ex_wdata = 32'h1234;
        mem_we = 1; mem_waddr = 0; mem_wdata = 32'h1234;
        wb_we = 1; wb_waddr = 0; wb_wdata = 32'h1234;
        ra[0] = 0; ra[1] = 0;
        lit_rd("r0_fwd", 0, 32'h0);
        chk("r0_stall", {63'd0, stall_req}, 64'd0);
        tick();
        clr_src();
        lit_rd("r0_arr", 1, 32'h0); tick();

        // five consecutive stalls: 16-bit counter reaches 6, 2-bit one saturates
        ex_we = 1; ex_is_load = 1; ex_waddr = 8; ra[0] = 8;
        repeat (5) tick();
        clr_src();
        #2;
        chk("sat_cnt_s", {62'd0, stall_cnt_s}, 64'd3);
        chk("sat_cnt", {48'd0, stall_cnt}, 64'd6);
        tick();

        // reset mid-stream with a WB write in flight and a hazard present
        rst = 1; wb_we = 1; wb_waddr = 7; wb_wdata = 32'hFF;
        ex_we = 1; ex_is_load = 1; ex_waddr = 7; ra[0] = 7; ra[1] = 7;
        lit_rd("rst_rd", 0, 32'h0);
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        tick();
        rst = 0; clr_src();
        lit_rd("rst_r7", 0, 32'h0);
        chk("rst_cnt", {48'd0, stall_cnt}, 64'd0);
        chk("rst_cnt_s", {62'd0, stall_cnt_s}, 64'd0);
        tick();
        ra[0] = 5;
        lit_rd("rst_r5", 0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
